// File: rtl/time_pkg.sv
// ============================================================================
// Module      : time_pkg
// Description : BCD types, limits and helpers shared by the time keeper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package time_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t SEC_MAX = 8'h59;
    localparam bcd2_t MIN_MAX = 8'h59;

    function automatic logic bcd2_valid(input bcd2_t v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Valid BCD orders the same as its binary encoding.
    function automatic logic bcd2_le(input bcd2_t a, input bcd2_t b);
        return a <= b;
    endfunction

    function automatic bcd2_t bcd2_inc(input bcd2_t v, input bcd2_t max_val);
        if (v == max_val) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'h0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// ============================================================================
// Module      : bcd_mod_counter
// Description : Two-digit BCD counter wrapping at max_val, with clear/load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mod_counter
    import time_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  inc,
    input  logic  clr,
    input  logic  ld,
    input  bcd2_t ld_val,
    input  bcd2_t max_val,
    output bcd2_t val,
    output logic  carry
);

    bcd2_t val_q;
    bcd2_t val_d;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = 8'h00;
        end else if (ld) begin
            val_d = ld_val;
        end else if (inc) begin
            val_d = bcd2_inc(val_q, max_val);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q <= 8'h00;
        end else begin
            val_q <= val_d;
        end
    end

    assign val   = val_q;
    assign carry = inc & (val_q == max_val);

endmodule

`default_nettype wire

// File: rtl/time_keeper.sv
// ============================================================================
// Module      : time_keeper
// Description : 24h BCD time of day driven by the 1 Hz seconds toggle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_keeper
    import time_pkg::*;
#(
    parameter int MAX_HOUR = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       seconds,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       tick,
    output logic       day_wrap,
    output logic       alarm,
    output logic       load_err
);

    localparam bcd2_t HOUR_MAX = bcd2_t'(((MAX_HOUR / 10) * 16) + (MAX_HOUR % 10));

    logic  sec_q;
    logic  tick_q;
    logic  day_wrap_q;
    logic  alarm_q;
    logic  load_err_q;

    logic  w_edge;
    logic  w_load_ok;
    logic  w_ld;
    logic  w_count;
    logic  w_alarm_hit;
    logic  w_ss_carry;
    logic  w_mm_carry;
    logic  w_hh_carry;
    bcd2_t w_hh;
    bcd2_t w_mm;
    bcd2_t w_ss;
    bcd2_t w_mm_next;
    bcd2_t w_hh_next;

    assign w_edge = seconds ^ sec_q;

    assign w_load_ok = bcd2_valid(load_hh) && bcd2_valid(load_mm) && bcd2_valid(load_ss)
                    && bcd2_le(load_hh, HOUR_MAX)
                    && bcd2_le(load_mm, MIN_MAX)
                    && bcd2_le(load_ss, SEC_MAX);

    // Any clear or load request, even a rejected one, swallows this cycle's second.
    assign w_ld    = load & ~clear & w_load_ok;
    assign w_count = w_edge & run & ~clear & ~load;

    bcd_mod_counter u_ss (
        .clk     (clk),
        .reset   (reset),
        .inc     (w_count),
        .clr     (clear),
        .ld      (w_ld),
        .ld_val  (load_ss),
        .max_val (SEC_MAX),
        .val     (w_ss),
        .carry   (w_ss_carry)
    );

    bcd_mod_counter u_mm (
        .clk     (clk),
        .reset   (reset),
        .inc     (w_ss_carry),
        .clr     (clear),
        .ld      (w_ld),
        .ld_val  (load_mm),
        .max_val (MIN_MAX),
        .val     (w_mm),
        .carry   (w_mm_carry)
    );

    bcd_mod_counter u_hh (
        .clk     (clk),
        .reset   (reset),
        .inc     (w_mm_carry),
        .clr     (clear),
        .ld      (w_ld),
        .ld_val  (load_hh),
        .max_val (HOUR_MAX),
        .val     (w_hh),
        .carry   (w_hh_carry)
    );

    // A second landing on xx:yy:00 always carries out of ss. The new time is
    // always valid BCD, so an invalid alarm setting can never compare equal.
    assign w_mm_next   = bcd2_inc(w_mm, MIN_MAX);
    assign w_hh_next   = w_mm_carry ? bcd2_inc(w_hh, HOUR_MAX) : w_hh;
    assign w_alarm_hit = alarm_en & w_ss_carry
                       & (w_mm_next == alarm_mm) & (w_hh_next == alarm_hh);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_q      <= 1'b0;
            tick_q     <= 1'b0;
            day_wrap_q <= 1'b0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            sec_q      <= seconds;
            tick_q     <= w_count;
            day_wrap_q <= w_hh_carry;
            alarm_q    <= w_alarm_hit;
            load_err_q <= load & ~clear & ~w_load_ok;
        end
    end

    assign hh       = w_hh;
    assign mm       = w_mm;
    assign ss       = w_ss;
    assign tick     = tick_q;
    assign day_wrap = day_wrap_q;
    assign alarm    = alarm_q;
    assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_time_keeper.sv
// ============================================================================
// Module      : tb_time_keeper
// Description : Directed bench for time_keeper (24h and 12h instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_keeper;

    localparam int MAXH [2] = '{23, 11};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       seconds = 1'b0;
    logic       run = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic       alarm_en = 1'b0;
    logic [7:0] load_hh = 8'h00;
    logic [7:0] load_mm = 8'h00;
    logic [7:0] load_ss = 8'h00;
    logic [7:0] alarm_hh = 8'h00;
    logic [7:0] alarm_mm = 8'h00;

    logic [1:0][7:0] d_hh, d_mm, d_ss;
    logic [1:0]      d_tick, d_dw, d_al, d_le;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    int cnt_tick [2] = '{0, 0};
    int cnt_dw   [2] = '{0, 0};
    int cnt_al   [2] = '{0, 0};
    int cnt_le   [2] = '{0, 0};

    // Reference model: time of day as a plain seconds count.
    int         t    [2] = '{0, 0};
    logic [3:0] ex_p [2] = '{4'h0, 4'h0};
    logic       m_prev = 1'b0;
    bit         m_cnt;

    always #5 clk = ~clk;

    time_keeper #(.MAX_HOUR(23)) dut0 (
        .clk(clk), .reset(reset), .seconds(seconds), .run(run), .clear(clear), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .hh(d_hh[0]), .mm(d_mm[0]), .ss(d_ss[0]),
        .tick(d_tick[0]), .day_wrap(d_dw[0]), .alarm(d_al[0]), .load_err(d_le[0])
    );

    time_keeper #(.MAX_HOUR(11)) dut1 (
        .clk(clk), .reset(reset), .seconds(seconds), .run(run), .clear(clear), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .hh(d_hh[1]), .mm(d_mm[1]), .ss(d_ss[1]),
        .tick(d_tick[1]), .day_wrap(d_dw[1]), .alarm(d_al[1]), .load_err(d_le[1])
    );

    function automatic int dec(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit ok(input logic [7:0] v, input int lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (dec(v) <= lim);
    endfunction

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [23:0] exp_time(input int i);
        return {bcd(t[i] / 3600), bcd((t[i] / 60) % 60), bcd(t[i] % 60)};
    endfunction

    function automatic logic [23:0] tm(input int i);
        return {d_hh[i], d_mm[i], d_ss[i]};
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk or posedge reset);
        m_cnt = (seconds != m_prev) && run;
        for (int i = 0; i < 2; i++) begin
            ex_p[i] = 4'h0;
            if (reset) begin
                t[i] = 0;
            end else if (clear) begin
                t[i] = 0;
            end else if (load) begin
                if (ok(load_hh, MAXH[i]) && ok(load_mm, 59) && ok(load_ss, 59))
                    t[i] = dec(load_hh) * 3600 + dec(load_mm) * 60 + dec(load_ss);
                else
                    ex_p[i][0] = 1'b1;
            end else if (m_cnt) begin
                t[i] = (t[i] + 1) % ((MAXH[i] + 1) * 3600);
                ex_p[i][3] = 1'b1;
                if (t[i] == 0) ex_p[i][2] = 1'b1;
                if (alarm_en && ok(alarm_hh, MAXH[i]) && ok(alarm_mm, 59)
                    && t[i] == dec(alarm_hh) * 3600 + dec(alarm_mm) * 60)
                    ex_p[i][1] = 1'b1;
            end
        end
        m_prev = reset ? 1'b0 : seconds;
    end

    always begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("time", i, {8'h00, tm(i)}, {8'h00, exp_time(i)});
                check("pulses", i, {28'h0, d_tick[i], d_dw[i], d_al[i], d_le[i]}, {28'h0, ex_p[i]});
                cnt_tick[i] += int'(d_tick[i]);
                cnt_dw[i]   += int'(d_dw[i]);
                cnt_al[i]   += int'(d_al[i]);
                cnt_le[i]   += int'(d_le[i]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic toggle();
        seconds = ~seconds;
        step();
        step();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load_hh = h;
        load_mm = m;
        load_ss = s;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
    endtask

    logic [23:0] prev;
    int          base;

    initial begin
        #1 reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset_time", 0, {8'h00, tm(0)}, 32'h0);
        check("reset_pulses", 1, {28'h0, d_tick[1], d_dw[1], d_al[1], d_le[1]}, 32'h0);
        chk_en = 1'b1;

        run = 1'b1;
        repeat (3) toggle();
        check("count3_ss", 0, {24'h0, d_ss[0]}, 32'h03);
        check("count3_ticks", 0, cnt_tick[0], 3);

        do_load(8'h23, 8'h59, 8'h58);
        check("load_235958", 0, {8'h00, tm(0)}, 32'h235958);
        check("load_hh23_rej12h", 1, cnt_le[1], 1);
        toggle();
        check("t_235959", 0, {8'h00, tm(0)}, 32'h235959);
        check("no_wrap_yet", 0, cnt_dw[0], 0);
        toggle();
        check("wrap_000000", 0, {8'h00, tm(0)}, 32'h000000);
        check("wrap_once", 0, cnt_dw[0], 1);

        do_load(8'h11, 8'h59, 8'h58);
        toggle();
        toggle();
        check("wrap12_000000", 1, {8'h00, tm(1)}, 32'h000000);
        check("wrap12_once", 1, cnt_dw[1], 1);
        check("no_wrap_at_12", 0, {8'h00, tm(0)}, 32'h120000);

        base = cnt_le[0];
        prev = tm(0);
        do_load(8'h12, 8'h00, 8'h60);
        do_load(8'h24, 8'h00, 8'h00);
        do_load(8'h12, 8'h3A, 8'h00);
        check("bad_load_held", 0, {8'h00, tm(0)}, {8'h00, prev});
        check("bad_load_errs", 0, cnt_le[0] - base, 3);

        base = cnt_le[0];
        load_hh = 8'h24;
        clear = 1'b1;
        load = 1'b1;
        step();
        clear = 1'b0;
        load = 1'b0;
        step();
        check("clr_ld_time", 0, {8'h00, tm(0)}, 32'h0);
        check("clr_ld_noerr", 0, cnt_le[0] - base, 0);

        alarm_hh = 8'h07;
        alarm_mm = 8'h30;
        alarm_en = 1'b1;
        do_load(8'h07, 8'h29, 8'h59);
        toggle();
        check("alarm_time", 0, {8'h00, tm(0)}, 32'h073000);
        check("alarm_fired", 0, cnt_al[0], 1);
        alarm_en = 1'b0;
        do_load(8'h07, 8'h29, 8'h59);
        toggle();
        check("alarm_off", 0, cnt_al[0], 1);
        alarm_en = 1'b1;
        do_load(8'h07, 8'h30, 8'h00);
        toggle();
        check("alarm_no_load_fire", 0, cnt_al[0], 1);

        base = cnt_tick[0];
        seconds = ~seconds;
        load_hh = 8'h10;
        load_mm = 8'h20;
        load_ss = 8'h30;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        check("coinc_load_time", 0, {8'h00, tm(0)}, 32'h102030);
        check("coinc_load_notick", 0, cnt_tick[0] - base, 0);
        seconds = ~seconds;
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        check("coinc_clr_time", 0, {8'h00, tm(0)}, 32'h0);
        check("coinc_clr_notick", 0, cnt_tick[0] - base, 0);

        do_load(8'h05, 8'h06, 8'h07);
        run = 1'b0;
        repeat (5) toggle();
        check("paused", 0, {8'h00, tm(0)}, 32'h050607);
        run = 1'b1;
        toggle();
        check("resume_plus1", 0, {8'h00, tm(0)}, 32'h050608);

        do_load(8'h12, 8'h34, 8'h56);
        @(negedge clk);
        #2;
        reset = 1'b1;
        seconds = 1'b0;
        #1;
        check("async_rst_time", 0, {8'h00, tm(0)}, 32'h0);
        check("async_rst_time", 1, {8'h00, tm(1)}, 32'h0);
        step();
        reset = 1'b0;
        step();
        toggle();
        check("after_rst_000001", 0, {8'h00, tm(0)}, 32'h000001);

        step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/time_keeper.md
# time_keeper

Downstream consumer of the 1 Hz `seconds` toggle produced by the clock divider. Every transition of `seconds` is one elapsed second. The block keeps a 24-hour BCD time of day (HH:MM:SS) and supports run/pause, clear and parallel load. It raises single-cycle tick, day-wrap and alarm pulses for the display and control logic.

## Interface
- `MAX_HOUR`, default 23: last hour value before wrap to 00. Legal range 1..23; 23 gives 24-hour mode.
- `clk` input 1: system clock, same domain as the divider.
- `reset` input 1: asynchronous, active-high; clears all state.
- `seconds` input 1: divider toggle; each rising or falling transition is one second.
- `run` input 1: level; 1 = count, 0 = paused.
- `clear` input 1: synchronous pulse; time becomes 00:00:00.
- `load` input 1: synchronous pulse; time becomes `load_hh:load_mm:load_ss`.
- `load_hh`, `load_mm`, `load_ss` input 8 each: two BCD digits, tens in [7:4], units in [3:0].
- `alarm_en` input 1: enables alarm compare.
- `alarm_hh`, `alarm_mm` input 8 each: BCD alarm time; the alarm second is fixed at 00.
- `hh`, `mm`, `ss` output 8 each: current time in BCD, registered.
- `tick` output 1: one-cycle pulse per counted second.
- `day_wrap` output 1: one-cycle pulse on MAX_HOUR:59:59 -> 00:00:00.
- `alarm` output 1: one-cycle pulse when a counted second lands on `alarm_hh:alarm_mm:00`.
- `load_err` output 1: one-cycle pulse when a load is rejected.

## Operation
- Edge detect:
  - `sec_d` register samples `seconds` every cycle; reset value 0, matching the divider's reset value.
  - `edge = seconds ^ sec_d`.
- Counted second: `edge & run`. Edges seen while `run=0` are discarded; there is no catch-up. `sec_d` tracks regardless of `run`.
- Increment:
  - ss 00..59, wrapping to 00 with carry into mm.
  - mm 00..59, wrapping with carry into hh.
  - hh 00..MAX_HOUR, wrapping to 00 and asserting `day_wrap`.
- Each digit pair is BCD throughout; units 9 -> 0 carries into tens.
- Priority per cycle: reset > clear > load > counted second.
  - Clear or load in the same cycle as a counted second drops that second: no `tick`, `alarm` or `day_wrap`.
  - Clear and load together: clear wins, and no `load_err` is raised.
- Load validation: a load is accepted only if every nibble is 0..9, hh ≤ MAX_HOUR, mm ≤ 59 and ss ≤ 59.
  - Otherwise time is unchanged and `load_err` pulses.
  - A rejected load still blocks a same-cycle counted second.
- Alarm: `alarm` = counted second, `alarm_en` = 1, and the new time equals `alarm_hh:alarm_mm:00`.
  - Loading or clearing onto the alarm time does not fire `alarm`.
  - An invalid alarm value never matches.
- Reset mid-count: all outputs return to their reset values immediately (asynchronously). Counting resumes on the first `seconds` transition after reset is released.

## Timing
- Reset values: `hh=mm=ss=8'h00`, `tick=day_wrap=alarm=load_err=0`, `sec_d=0`.
- Counted second: `seconds` changes in cycle k, and time, `tick`, `day_wrap` and `alarm` update at the clock edge ending cycle k. Latency from the `seconds` transition to updated outputs is one clock edge.
- Clear and load: take effect at the same edge they are sampled high. `load_err` is valid in the following cycle.
- All pulse outputs are registered and last exactly one cycle.
- No combinational path from input to output.
- Minimum spacing between `seconds` transitions is 2 cycles. Closer spacing is outside specification.

## Structure
- Package `time_pkg`:
  - `bcd2_t` (8-bit two-digit BCD) typedef.
  - Constants `SEC_MAX=8'h59`, `MIN_MAX=8'h59`.
  - Function `bcd2_valid` (nibble check).
  - Function `bcd2_le` (BCD compare).
- Sub-module `bcd_mod_counter`: two-digit BCD modulo counter.
  - Inputs: `clk`, `reset`, `inc`, `clr`, `ld`, `ld_val`, `max_val`.
  - Outputs: `val`, `carry` (combinational: `inc & val==max_val`).
  - Instantiated three times, chained by carry.
- Top holds edge detect, load validation, priority logic and pulse registers.

## Test plan
- Reset, then run=1 with 3 toggles of `seconds` → `ss` goes 01, 02, 03; exactly 3 `tick` pulses.
- Load 23:59:58 then 2 toggles → 23:59:59, then 00:00:00 with `day_wrap` on the second tick only. Repeat with MAX_HOUR=11: 11:59:59 → 00:00:00.
- Invalid loads rejected with one `load_err` pulse each and time held:
  - `load_ss=8'h60`
  - `load_hh=8'h24`
  - `load_mm=8'h3A`
- Alarm at 07:30: load 07:29:59 with alarm_en=1, toggle → `alarm` pulses once at 07:30:00. Same sequence with alarm_en=0 → no pulse. Loading 07:30:00 directly → no pulse.
- Load or clear coincident with a `seconds` transition → load/clear value visible, no `tick`.
- run=0 for 5 toggles → time frozen. Set run=1 and toggle once → time advances by exactly 1.
- Reset asserted mid-count at 12:34:56 → outputs read 00:00:00 immediately. The first toggle after release gives 00:00:01.
